regfile_alu_pipe: RTL and testbench
===================================

# regfile_alu_pipe

Parametrised register bank fused with a two-stage ALU pipeline: operand read, execute, write-back into the bank. Successor to the fixed 16×16 bank-plus-ALU pairing of the Lapido datapath; generalises width and depth, adds forwarding, condition flags, a valid/ready handshake and a sequenced bank-clear. Sits between the control unit (issues ops) and the memory/IO path (consumes `result`).

## Interface
Parameters:
- `WIDTH`, 16, data word width (≥4)
- `DEPTH`, 16, number of registers (power of two, ≥2)
- `AW`, $clog2(DEPTH), register address width (derived, not overridable)

Ports:
- `clock`  in  1  rising-edge clock, single clock domain
- `reset`  in  1  asynchronous, active-low reset
- `op_valid`  in  1  op presented this cycle
- `op_ready`  out  1  block can accept an op
- `op_code`  in  4  operation, encoding in package
- `rd_a`  in  AW  destination and source-A register (same address)
- `rs_b`  in  AW  source-B register
- `use_imm`  in  1  1: operand B = `imm` instead of bank[rs_b]
- `imm`  in  WIDTH  immediate operand
- `clear_req`  in  1  pulse: zero entire bank
- `result`  out  WIDTH  ALU result of retiring op
- `res_valid`  out  1  `result`/`flags` valid, one-cycle pulse per op
- `flags`  out  4  {Z,N,C,V} of retiring op, held until next retire

## Operation
- Accept: op taken when `op_valid && op_ready`.
- Stage 1 (READ): latch A = bank[rd_a], B = use_imm ? imm : bank[rs_b], op, dest.
- Stage 2 (EXEC): compute, drive `result`/`flags`, pulse `res_valid`, write bank[dest] on the same edge unless op is CMP or NOP.
- Ops: NOP, ADD, SUB, AND, OR, XOR, NOT(A), SHL, SHR (logical, amount B[$clog2(WIDTH)-1:0]), PASS_B, CMP (SUB without write-back).
- Arithmetic: compute at WIDTH+1 bits. ADD: C = bit WIDTH. SUB/CMP: C = 1 when A ≥ B unsigned (no borrow). V = two's-complement overflow for ADD/SUB/CMP, 0 otherwise. C = 0 for logic ops; SHL/SHR C = last bit shifted out (0 if amount 0). Z = result==0, N = result[WIDTH-1].
- Forwarding: if stage 2 writes register R in the cycle stage 1 reads R (A or non-imm B), stage 1 takes the stage-2 result, not the stale bank value. Back-to-back dependent ops run with no bubble.
- FSM: RUN (op_ready=1) and CLEAR (op_ready=0). `clear_req` in RUN → CLEAR after in-flight ops drain; CLEAR zeroes one register per cycle, index 0..DEPTH-1, then returns to RUN. `clear_req` during CLEAR ignored. Op offered together with `clear_req` is not accepted (op_ready drops the same cycle, combinationally from `clear_req`).

## Timing
- Latency: accept at edge N → `res_valid`, `result` and bank write at edge N+2 (visible after it).
- Throughput: one op per cycle in RUN.
- CLEAR: `op_ready` low from `clear_req` cycle until in-flight ops drain + DEPTH cycles; first op accepted the cycle after last register cleared.
- Reset (async assert, sync deassert by caller): all registers 0, pipeline empty, state RUN, `op_ready`=1, `res_valid`=0, `result`=0, `flags`=0. Reset mid-op discards in-flight ops; no partial write.
- Same-address write-then-read with no forwarding hazard reads the new value (bank written at edge, read after).

## Structure
- Package `lapido_alu_pkg`: op_code enum, flag bit indices, state enum.
- Sub-module `alu_core` (combinational: WIDTH param, A, B, op → result, flags); pipeline, bank, forwarding and FSM in top.

## Test plan
- Reset, then ADD r1←r1+imm 5, then ADD r1←r1+imm 7 back-to-back → results 5 then 12 on consecutive `res_valid`; r1 = 12 (forwarding).
- WIDTH=16: PASS_B imm 0x7FFF into r2, ADD r2+imm 1 → result 0x8000, flags N=1,V=1,C=0,Z=0.
- CMP r3 (=3) vs imm 3 → Z=1,C=1; r3 unchanged; SUB 3−5 → 0xFFFE, C=0,N=1.
- SHL of 0x8001 by 1 → 0x0002, C=1; SHR by 0 → unchanged, C=0.
- Load r0..r15 nonzero, `clear_req` with op in flight → op retires and writes, `op_ready` low 16+drain cycles, all registers read 0 afterward.
- Assert `reset` mid-pipeline → `res_valid` never pulses for discarded ops; all outputs 0; bank zero.

Source files
------------

// File: rtl/lapido_alu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : lapido_alu_pkg
// Brief    : Op codes, flag bit positions and FSM states for regfile_alu_pipe
// Revision : 1.0
// ============================================================================
package lapido_alu_pkg;

    // Undefined codes behave like NOP: result 0 and no write-back.
    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,
        OP_ADD    = 4'd1,
        OP_SUB    = 4'd2,
        OP_AND    = 4'd3,
        OP_OR     = 4'd4,
        OP_XOR    = 4'd5,
        OP_NOT    = 4'd6,
        OP_SHL    = 4'd7,
        OP_SHR    = 4'd8,
        OP_PASS_B = 4'd9,
        OP_CMP    = 4'd10
    } op_e;

    // flags = {Z,N,C,V}
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    function automatic logic op_writes(input op_e op);
        logic wr;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_NOT, OP_SHL, OP_SHR, OP_PASS_B: wr = 1'b1;
            default:                           wr = 1'b0;
        endcase
        return wr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Interface : regfile_alu_pipe_if
// Brief     : Op-issue handshake and result bus between control unit and datapath
// Revision  : 1.0
// ============================================================================
interface regfile_alu_pipe_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic             op_valid;
    logic             op_ready;
    logic [3:0]       op_code;
    logic [AW-1:0]    rd_a;
    logic [AW-1:0]    rs_b;
    logic             use_imm;
    logic [WIDTH-1:0] imm;
    logic             clear_req;
    logic [WIDTH-1:0] result;
    logic             res_valid;
    logic [3:0]       flags;

    modport master (
        output op_valid, op_code, rd_a, rs_b, use_imm, imm, clear_req,
        input  op_ready, result, res_valid, flags
    );

    modport slave (
        input  op_valid, op_code, rd_a, rs_b, use_imm, imm, clear_req,
        output op_ready, result, res_valid, flags
    );

endinterface
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_core
// Brief    : Combinational ALU producing a WIDTH-bit result and {Z,N,C,V}
// Revision : 1.0
// ============================================================================
module alu_core
    import lapido_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  op_e              i_op,
    output logic [WIDTH-1:0] o_result,
    output logic [3:0]       o_flags
);
    localparam int SW  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic [SW-1:0]    w_amt;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;

    assign w_amt  = i_b[SW-1:0];
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};
    // One spare bit on the exit side catches the last bit shifted out.
    assign w_shl  = {1'b0, i_a} << w_amt;
    assign w_shr  = {i_a, 1'b0} >> w_amt;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (i_a[MSB] == i_b[MSB]) && (w_res[MSB] != i_a[MSB]);
            end
            OP_SUB, OP_CMP: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = ~w_diff[WIDTH];
                w_v   = (i_a[MSB] != i_b[MSB]) && (w_res[MSB] != i_a[MSB]);
            end
            OP_AND:    w_res = i_a & i_b;
            OP_OR:     w_res = i_a | i_b;
            OP_XOR:    w_res = i_a ^ i_b;
            OP_NOT:    w_res = ~i_a;
            OP_PASS_B: w_res = i_b;
            OP_SHL: begin
                w_res = w_shl[WIDTH-1:0];
                w_c   = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_res = w_shr[WIDTH:1];
                w_c   = w_shr[0];
            end
            default: w_res = '0;
        endcase
    end

    assign o_result        = w_res;
    assign o_flags[FLAG_Z] = (w_res == '0);
    assign o_flags[FLAG_N] = w_res[MSB];
    assign o_flags[FLAG_C] = w_c;
    assign o_flags[FLAG_V] = w_v;

endmodule
`default_nettype wire

// File: rtl/regfile_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : regfile_alu_pipe
// Brief    : Register bank with a forwarded read/execute pipeline and sequenced clear
// Revision : 1.0
// ============================================================================
module regfile_alu_pipe
    import lapido_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    regfile_alu_pipe_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);

    state_e           state_q,   state_d;
    logic [AW-1:0]    clr_idx_q, clr_idx_d;
    logic [WIDTH-1:0] bank_q [DEPTH];
    logic [WIDTH-1:0] bank_d [DEPTH];

    // Issue stage: op captured at accept, operands read during the next cycle.
    logic             s1_valid_q,   s1_valid_d;
    op_e              s1_op_q,      s1_op_d;
    logic [AW-1:0]    s1_ra_q,      s1_ra_d;
    logic [AW-1:0]    s1_rb_q,      s1_rb_d;
    logic             s1_use_imm_q, s1_use_imm_d;
    logic [WIDTH-1:0] s1_imm_q,     s1_imm_d;

    logic             s2_valid_q,   s2_valid_d;
    op_e              s2_op_q,      s2_op_d;
    logic [AW-1:0]    s2_dest_q,    s2_dest_d;
    logic [WIDTH-1:0] s2_a_q,       s2_a_d;
    logic [WIDTH-1:0] s2_b_q,       s2_b_d;

    logic [WIDTH-1:0] result_q,     result_d;
    logic [3:0]       flags_q,      flags_d;
    logic             res_valid_q,  res_valid_d;

    logic             w_op_ready;
    logic             w_accept;
    logic             w_s2_wr;
    logic             w_drained;
    logic             w_clr_en;
    logic [WIDTH-1:0] w_alu_res;
    logic [3:0]       w_alu_flags;
    logic [WIDTH-1:0] w_opnd_a;
    logic [WIDTH-1:0] w_opnd_b;

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .i_a      (s2_a_q),
        .i_b      (s2_b_q),
        .i_op     (s2_op_q),
        .o_result (w_alu_res),
        .o_flags  (w_alu_flags)
    );

    assign w_op_ready = (state_q == ST_RUN) && !bus.clear_req;
    assign w_accept   = bus.op_valid && w_op_ready;
    assign w_s2_wr    = s2_valid_q && op_writes(s2_op_q);
    assign w_drained  = !s1_valid_q && !s2_valid_q;
    assign w_clr_en   = (state_q == ST_CLEAR) && w_drained;

    // The retiring op writes the bank on the same edge these operands are
    // latched, so its result must bypass the bank.
    assign w_opnd_a = (w_s2_wr && (s2_dest_q == s1_ra_q)) ? w_alu_res : bank_q[s1_ra_q];
    assign w_opnd_b = s1_use_imm_q                        ? s1_imm_q  :
                      (w_s2_wr && (s2_dest_q == s1_rb_q)) ? w_alu_res : bank_q[s1_rb_q];

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_RUN: begin
                if (bus.clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end
            end
            ST_CLEAR: begin
                if (w_clr_en) begin
                    clr_idx_d = clr_idx_q + 1'b1;
                    if (clr_idx_q == AW'(DEPTH - 1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase

        s1_valid_d   = w_accept;
        s1_op_d      = w_accept ? op_e'(bus.op_code) : s1_op_q;
        s1_ra_d      = w_accept ? bus.rd_a    : s1_ra_q;
        s1_rb_d      = w_accept ? bus.rs_b    : s1_rb_q;
        s1_use_imm_d = w_accept ? bus.use_imm : s1_use_imm_q;
        s1_imm_d     = w_accept ? bus.imm     : s1_imm_q;

        s2_valid_d   = s1_valid_q;
        s2_op_d      = s1_valid_q ? s1_op_q  : s2_op_q;
        s2_dest_d    = s1_valid_q ? s1_ra_q  : s2_dest_q;
        s2_a_d       = s1_valid_q ? w_opnd_a : s2_a_q;
        s2_b_d       = s1_valid_q ? w_opnd_b : s2_b_q;

        res_valid_d  = s2_valid_q;
        result_d     = s2_valid_q ? w_alu_res   : result_q;
        flags_d      = s2_valid_q ? w_alu_flags : flags_q;

        bank_d = bank_q;
        if (w_s2_wr) begin
            bank_d[s2_dest_q] = w_alu_res;
        end
        if (w_clr_en) begin
            bank_d[clr_idx_q] = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            clr_idx_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
            s1_valid_q   <= 1'b0;
            s1_op_q      <= OP_NOP;
            s1_ra_q      <= '0;
            s1_rb_q      <= '0;
            s1_use_imm_q <= 1'b0;
            s1_imm_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_op_q      <= OP_NOP;
            s2_dest_q    <= '0;
            s2_a_q       <= '0;
            s2_b_q       <= '0;
            result_q     <= '0;
            flags_q      <= '0;
            res_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            bank_q       <= bank_d;
            s1_valid_q   <= s1_valid_d;
            s1_op_q      <= s1_op_d;
            s1_ra_q      <= s1_ra_d;
            s1_rb_q      <= s1_rb_d;
            s1_use_imm_q <= s1_use_imm_d;
            s1_imm_q     <= s1_imm_d;
            s2_valid_q   <= s2_valid_d;
            s2_op_q      <= s2_op_d;
            s2_dest_q    <= s2_dest_d;
            s2_a_q       <= s2_a_d;
            s2_b_q       <= s2_b_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
            res_valid_q  <= res_valid_d;
        end
    end

    assign bus.op_ready  = w_op_ready;
    assign bus.result    = result_q;
    assign bus.res_valid = res_valid_q;
    assign bus.flags     = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_alu_pipe
// Brief    : Vector table plus scoreboard bench for regfile_alu_pipe (16x16)
// Revision : 1.0
// ============================================================================
module tb_regfile_alu_pipe;
    import lapido_alu_pkg::*;

    localparam int W = 16;
    localparam int D = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    regfile_alu_pipe_if #(.WIDTH(W), .DEPTH(D)) bus ();

    regfile_alu_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] res;
        logic [3:0]  fl;
        int          cyc;
        int          tag;
    } exp_t;

    typedef struct {
        op_e         op;
        int          rd;
        int          rs;
        logic        ui;
        logic [15:0] imm;
        logic [15:0] er;
        logic [3:0]  ef;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[23];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [3:0] flags_of(input logic [15:0] v);
        return {v == 16'h0000, v[15], 2'b00};
    endfunction

    // Scoreboard consumer
    always @(negedge clock) begin
        exp_t e;
        if (reset && bus.res_valid !== 1'b0) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_res_valid actual=%b required=0 result=%0h", bus.res_valid, bus.result);
            end else begin
                e = sb.pop_front();
                check($sformatf("result[%0d]", e.tag),  bus.result, e.res);
                check($sformatf("flags[%0d]", e.tag),   bus.flags,  e.fl);
                check($sformatf("latency[%0d]", e.tag), cyc,        e.cyc);
            end
        end
    end

    task automatic issue(input op_e op, input int rd, input int rs, input logic ui,
                         input logic [15:0] imm, input logic [15:0] er,
                         input logic [3:0] ef, input int tag);
        int   waited;
        exp_t e;
        @(negedge clock);
        bus.op_code  = op;
        bus.rd_a     = 4'(rd);
        bus.rs_b     = 4'(rs);
        bus.use_imm  = ui;
        bus.imm      = imm;
        bus.op_valid = 1'b1;
        waited = 0;
        while (bus.op_ready !== 1'b1 && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        if (bus.op_ready !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout[%0d] actual=op_ready_low required=op_ready_high", tag);
            bus.op_valid = 1'b0;
        end else begin
            e.res = er;
            e.fl  = ef;
            e.cyc = cyc + 3;
            e.tag = tag;
            sb.push_back(e);
            @(posedge clock);
            #1;
            bus.op_valid = 1'b0;
        end
    endtask

    task automatic read_reg(input int r, input logic [15:0] v, input int tag);
        issue(OP_OR, r, 0, 1'b1, 16'h0000, v, flags_of(v), tag);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout actual=%0d required=0 pending results", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        exp_t e;

        bus.op_valid  = 1'b0;
        bus.op_code   = 4'd0;
        bus.rd_a      = '0;
        bus.rs_b      = '0;
        bus.use_imm   = 1'b0;
        bus.imm       = '0;
        bus.clear_req = 1'b0;

        tbl[0]  = '{OP_ADD,    1, 0, 1'b1, 16'h0005, 16'h0005, 4'b0000};
        tbl[1]  = '{OP_ADD,    1, 0, 1'b1, 16'h0007, 16'h000C, 4'b0000};
        tbl[2]  = '{OP_PASS_B, 2, 0, 1'b1, 16'h7FFF, 16'h7FFF, 4'b0000};
        tbl[3]  = '{OP_ADD,    2, 0, 1'b1, 16'h0001, 16'h8000, 4'b0101};
        tbl[4]  = '{OP_PASS_B, 3, 0, 1'b1, 16'h0003, 16'h0003, 4'b0000};
        tbl[5]  = '{OP_CMP,    3, 0, 1'b1, 16'h0003, 16'h0000, 4'b1010};
        tbl[6]  = '{OP_SUB,    3, 0, 1'b1, 16'h0005, 16'hFFFE, 4'b0100};
        tbl[7]  = '{OP_PASS_B, 4, 0, 1'b1, 16'h8001, 16'h8001, 4'b0100};
        tbl[8]  = '{OP_SHL,    4, 0, 1'b1, 16'h0001, 16'h0002, 4'b0010};
        tbl[9]  = '{OP_SHR,    4, 0, 1'b1, 16'h0000, 16'h0002, 4'b0000};
        tbl[10] = '{OP_SHR,    4, 0, 1'b1, 16'h0002, 16'h0000, 4'b1010};
        tbl[11] = '{OP_OR,     1, 2, 1'b0, 16'h0000, 16'h800C, 4'b0100};
        tbl[12] = '{OP_XOR,    1, 1, 1'b0, 16'h0000, 16'h0000, 4'b1000};
        tbl[13] = '{OP_ADD,    5, 0, 1'b1, 16'hFFFF, 16'hFFFF, 4'b0100};
        tbl[14] = '{OP_ADD,    5, 0, 1'b1, 16'h0001, 16'h0000, 4'b1010};
        tbl[15] = '{OP_NOT,    2, 0, 1'b1, 16'h0000, 16'h7FFF, 4'b0000};
        tbl[16] = '{OP_AND,    2, 3, 1'b0, 16'h0000, 16'h7FFE, 4'b0000};
        tbl[17] = '{OP_SUB,    2, 0, 1'b1, 16'h7FFF, 16'hFFFF, 4'b0100};
        tbl[18] = '{OP_OR,     3, 0, 1'b1, 16'h0000, 16'hFFFE, 4'b0100};
        tbl[19] = '{OP_SUB,    6, 0, 1'b1, 16'h0001, 16'hFFFF, 4'b0100};
        tbl[20] = '{OP_PASS_B, 7, 0, 1'b1, 16'h8000, 16'h8000, 4'b0100};
        tbl[21] = '{OP_SUB,    7, 0, 1'b1, 16'h0001, 16'h7FFF, 4'b0011};
        tbl[22] = '{OP_SHL,    7, 0, 1'b1, 16'h000F, 16'h8000, 4'b0110};

        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_op_ready",  bus.op_ready,  1);
        check("reset_res_valid", bus.res_valid, 0);
        check("reset_result",    bus.result,    0);
        check("reset_flags",     bus.flags,     0);
        reset = 1'b1;

        // Back-to-back vectors, exercising forwarding on A and B
        for (int i = 0; i < 23; i++) begin
            issue(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].ui, tbl[i].imm,
                  tbl[i].er, tbl[i].ef, i);
        end
        wait_drain();

        // Same register read one cycle after its write, no bypass involved
        issue(OP_PASS_B, 11, 0, 1'b1, 16'h0010, 16'h0010, 4'b0000, 100);
        @(negedge clock);
        issue(OP_ADD, 11, 0, 1'b1, 16'h0001, 16'h0011, 4'b0000, 101);
        wait_drain();

        // Load every register, then request a clear with an op still in flight
        for (int r = 0; r < D; r++) begin
            issue(OP_PASS_B, r, 0, 1'b1, 16'(r * 16'h0111 + 1),
                  16'(r * 16'h0111 + 1), flags_of(16'(r * 16'h0111 + 1)), 200 + r);
        end
        issue(OP_ADD, 0, 0, 1'b1, 16'h0100, 16'h0101, 4'b0000, 220);

        @(negedge clock);
        bus.op_code   = OP_PASS_B;
        bus.rd_a      = 4'd9;
        bus.rs_b      = 4'd0;
        bus.use_imm   = 1'b1;
        bus.imm       = 16'h0055;
        bus.op_valid  = 1'b1;
        bus.clear_req = 1'b1;
        #1;
        check("clear_req_blocks_ready", bus.op_ready, 0);
        @(posedge clock);
        #1;
        bus.clear_req = 1'b0;
        lows = 1;
        while (lows < 100) begin
            @(negedge clock);
            if (bus.op_ready === 1'b1) break;
            lows++;
        end
        check("clear_ready_low_cycles", lows, D + 2);
        if (bus.op_ready === 1'b1) begin
            e.res = 16'h0055;
            e.fl  = 4'b0000;
            e.cyc = cyc + 3;
            e.tag = 230;
            sb.push_back(e);
            @(posedge clock);
            #1;
        end
        bus.op_valid = 1'b0;
        wait_drain();

        for (int r = 0; r < D; r++) begin
            read_reg(r, (r == 9) ? 16'h0055 : 16'h0000, 300 + r);
        end
        wait_drain();

        // Reset with two ops in flight: neither may retire or write
        issue(OP_PASS_B, 10, 0, 1'b1, 16'hABCD, 16'hABCD, 4'b0100, 400);
        issue(OP_ADD,     9, 0, 1'b1, 16'h0001, 16'h0056, 4'b0000, 401);
        reset = 1'b0;
        sb.delete();
        #1;
        check("midreset_res_valid", bus.res_valid, 0);
        check("midreset_result",    bus.result,    0);
        check("midreset_flags",     bus.flags,     0);
        check("midreset_op_ready",  bus.op_ready,  1);
        repeat (2) begin
            @(negedge clock);
            check("inreset_res_valid", bus.res_valid, 0);
        end
        reset = 1'b1;
        repeat (4) @(negedge clock);
        for (int r = 0; r < D; r++) begin
            read_reg(r, 16'h0000, 500 + r);
        end
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
